// File: rtl/whack_a_mole_scorer.sv
// whack_a_mole_scorer: classifies mole windows as hits/misses and tracks reaction times.
// Define SCORER_PENALTY_EN to count false whacks and deduct a hit for each one.
module whack_a_mole_scorer #(
  parameter int SCORE_W     = 8,
  parameter int REACT_W     = 10,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ms_tick,
  input  logic               game_in_progress,
  input  logic               mole_up_window,
  input  logic               whack_button,
  output logic [SCORE_W-1:0] hits,
  output logic [SCORE_W-1:0] misses,
  output logic [SCORE_W-1:0] false_whacks,
  output logic               hit_pulse,
  output logic               miss_pulse,
  output logic [REACT_W-1:0] reaction_ms,
  output logic [REACT_W-1:0] best_reaction_ms,
  output logic [1:0]         dbg_state
);
  typedef enum logic [1:0] {IDLE = 2'd0, DOWN = 2'd1, ARMED = 2'd2, WHACKED = 2'd3} state_t;
  state_t state, nxt;
  logic [SYNC_STAGES-1:0] sync;
  logic press_q, mu_q, gip_q;
  logic press, rise, fall, start;
  logic hit, miss, game_clr, rcnt_clr;
  logic [REACT_W-1:0] rcnt, rval;
  assign press = sync[SYNC_STAGES-1] & ~press_q;
  assign rise = mole_up_window & ~mu_q;
  assign fall = ~mole_up_window & mu_q;
  assign start = game_in_progress & ~gip_q;
  assign dbg_state = state;
  // gip_q resets high so a game already running at reset release is not seen as a start
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= '0;
      press_q <= 1'b0;
      mu_q <= 1'b0;
      gip_q <= 1'b1;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], whack_button};
      press_q <= sync[SYNC_STAGES-1];
      mu_q <= mole_up_window;
      gip_q <= game_in_progress;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= nxt;
  end
  always_comb begin
    nxt = state;
    if (state == IDLE) nxt = start ? (mole_up_window ? ARMED : DOWN) : IDLE;
    else if (!game_in_progress) nxt = IDLE;
    else if (state == DOWN) nxt = rise ? (press ? WHACKED : ARMED) : DOWN;
    else if (state == ARMED) nxt = fall ? DOWN : (press ? WHACKED : ARMED);
    else nxt = fall ? DOWN : WHACKED;
  end
  always_comb begin
    hit = game_in_progress && press && ((state == DOWN && rise) || (state == ARMED && mole_up_window));
    miss = game_in_progress && fall && state == ARMED;
    game_clr = state == IDLE && start;
    rcnt_clr = game_clr || (state == DOWN && rise);
    rval = (state == ARMED) ? rcnt : '0;
  end
`ifdef SCORER_PENALTY_EN
  logic fw;
  assign fw = game_in_progress && press && !rise && state == DOWN;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) false_whacks <= '0;
    else if (game_clr) false_whacks <= '0;
    else if (fw && !(&false_whacks)) false_whacks <= false_whacks + SCORE_W'(1);
  end
`else
  assign false_whacks = '0;
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hits <= '0;
      misses <= '0;
      reaction_ms <= '0;
      best_reaction_ms <= '1;
      hit_pulse <= 1'b0;
      miss_pulse <= 1'b0;
      rcnt <= '0;
    end else begin
      hit_pulse <= hit;
      miss_pulse <= miss;
      rcnt <= rcnt_clr ? '0 : (state == ARMED && ms_tick && !(&rcnt)) ? rcnt + REACT_W'(1) : rcnt;
      if (game_clr) begin
        hits <= '0;
        misses <= '0;
        reaction_ms <= '0;
      end else begin
        if (hit) begin
          hits <= (&hits) ? hits : hits + SCORE_W'(1);
          reaction_ms <= rval;
          best_reaction_ms <= (rval < best_reaction_ms) ? rval : best_reaction_ms;
        end
`ifdef SCORER_PENALTY_EN
        else if (fw) hits <= (hits == '0) ? hits : hits - SCORE_W'(1);
`endif
        if (miss) misses <= (&misses) ? misses : misses + SCORE_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_whack_a_mole_scorer.sv
// tb_whack_a_mole_scorer: directed and random stimulus against a game-rule reference model.
module tb_whack_a_mole_scorer;
  localparam int S = 2;
  localparam int SMAX = 255;
  localparam int RMAX = 1023;
  logic clk = 1'b0, rst = 1'b1;
  logic ms_tick = 1'b0, game_in_progress = 1'b0, mole_up_window = 1'b0, whack_button = 1'b0;
  logic [7:0] hits, misses, false_whacks;
  logic hit_pulse, miss_pulse;
  logic [9:0] reaction_ms, best_reaction_ms;
  logic [1:0] dbg_state;
  whack_a_mole_scorer #(.SCORE_W(8), .REACT_W(10), .SYNC_STAGES(S)) dut (
    .clk(clk), .rst(rst), .ms_tick(ms_tick), .game_in_progress(game_in_progress),
    .mole_up_window(mole_up_window), .whack_button(whack_button), .hits(hits), .misses(misses),
    .false_whacks(false_whacks), .hit_pulse(hit_pulse), .miss_pulse(miss_pulse),
    .reaction_ms(reaction_ms), .best_reaction_ms(best_reaction_ms), .dbg_state(dbg_state)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;
  int tests = 0, fails = 0;
  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
    end
  endtask
  typedef struct {int cyc; int st; int h; int m; int f; int r; int b;} snap_t;
  typedef struct {int cyc; bit is_hit;} ev_t;
  snap_t snap_q[$];
  ev_t ev_q[$];
  // reference model: game rules in terms of "playing", "mole open for scoring", "already scored"
  bit playing, up_open, got_it, g_prev, mu_prev;
  int m_hits, m_miss, m_fw, m_react, m_best, m_ms;
  bit bh[$];
  task automatic model_reset();
    playing = 0; up_open = 0; got_it = 0;
    m_hits = 0; m_miss = 0; m_fw = 0; m_react = 0; m_best = RMAX; m_ms = 0;
    g_prev = game_in_progress; mu_prev = mole_up_window;
    bh.delete();
    for (int i = 0; i <= S; i++) bh.push_back(1'b0);
    bh.push_back(whack_button);
    snap_q.delete();
    ev_q.delete();
  endtask
  task automatic model_step(input bit g, input bit mu, input bit tk, input bit b);
    bit p, rise, fall, start, missed;
    int react_now;
    bh.push_back(b);
    p = bh[bh.size()-1-S] && !bh[bh.size()-2-S];
    void'(bh.pop_front());
    rise = mu && !mu_prev;
    fall = !mu && mu_prev;
    start = g && !g_prev;
    react_now = -1;
    missed = 0;
    if (!playing) begin
      if (start) begin
        playing = 1; up_open = mu; got_it = 0; m_ms = 0;
        m_hits = 0; m_miss = 0; m_fw = 0; m_react = 0;
      end
    end else if (!g) begin
      playing = 0; up_open = 0; got_it = 0;
    end else if (up_open) begin
      if (fall) begin missed = 1; up_open = 0; end
      else if (p) begin react_now = m_ms; up_open = 0; got_it = 1; end
      else if (tk) m_ms = (m_ms < RMAX) ? m_ms + 1 : RMAX;
    end else if (got_it) begin
      if (fall) got_it = 0;
    end else if (rise) begin
      m_ms = 0;
      if (p) begin react_now = 0; got_it = 1; end
      else up_open = 1;
    end else if (p) begin
`ifdef SCORER_PENALTY_EN
      m_fw = (m_fw < SMAX) ? m_fw + 1 : SMAX;
      m_hits = (m_hits > 0) ? m_hits - 1 : 0;
`endif
    end
    if (react_now >= 0) begin
      m_hits = (m_hits < SMAX) ? m_hits + 1 : SMAX;
      m_react = react_now;
      if (react_now < m_best) m_best = react_now;
      ev_q.push_back('{cyc + 1, 1'b1});
    end
    if (missed) begin
      m_miss = (m_miss < SMAX) ? m_miss + 1 : SMAX;
      ev_q.push_back('{cyc + 1, 1'b0});
    end
    snap_q.push_back('{cyc + 1, !playing ? 0 : up_open ? 2 : got_it ? 3 : 1,
                       m_hits, m_miss, m_fw, m_react, m_best});
    mu_prev = mu;
    g_prev = g;
  endtask
  task automatic cyc1(input bit g, input bit mu, input bit tk, input bit b);
    @(posedge clk);
    #1;
    game_in_progress = g; mole_up_window = mu; ms_tick = tk; whack_button = b;
    model_step(g, mu, tk, b);
  endtask
  task automatic check_reset(input string tag);
    chk({tag, "_hits"}, hits, 0);
    chk({tag, "_misses"}, misses, 0);
    chk({tag, "_false_whacks"}, false_whacks, 0);
    chk({tag, "_pulses"}, {hit_pulse, miss_pulse}, 0);
    chk({tag, "_reaction"}, reaction_ms, 0);
    chk({tag, "_best"}, best_reaction_ms, RMAX);
    chk({tag, "_state"}, dbg_state, 0);
  endtask
  task automatic do_reset();
    #2 rst = 1'b1;
    model_reset();
    #1 check_reset("midrst");
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
  endtask
  snap_t s;
  ev_t e;
  always @(negedge clk) begin
    if (!rst) begin
      if (snap_q.size() > 0 && snap_q[0].cyc == cyc) begin
        s = snap_q.pop_front();
        chk("dbg_state", dbg_state, s.st);
        chk("hits", hits, s.h);
        chk("misses", misses, s.m);
        chk("false_whacks", false_whacks, s.f);
        chk("reaction_ms", reaction_ms, s.r);
        chk("best_reaction_ms", best_reaction_ms, s.b);
      end
      if (ev_q.size() > 0 && ev_q[0].cyc == cyc) begin
        e = ev_q.pop_front();
        chk("hit_pulse", hit_pulse, e.is_hit);
        chk("miss_pulse", miss_pulse, !e.is_hit);
      end else if (hit_pulse || miss_pulse) chk("spurious_pulse", {hit_pulse, miss_pulse}, 0);
    end
  end
  int g_left = 0, m_left = 0, b_left = 0;
  bit g_r = 0, m_r = 0, b_r = 0;
  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1 check_reset("init");
    #1 rst = 1'b0;
    // basic hit: three ticks while armed, reaction 3
    cyc1(0, 0, 0, 0);
    cyc1(1, 0, 0, 0);
    cyc1(1, 0, 0, 0);
    cyc1(1, 1, 0, 0);
    for (int k = 0; k < 3; k++) begin
      cyc1(1, 1, 1, 0);
      cyc1(1, 1, 0, 0);
    end
    repeat (5) cyc1(1, 1, 0, 1);
    @(negedge clk);
    chk("basic_hits", hits, 1);
    chk("basic_reaction", reaction_ms, 3);
    chk("basic_best", best_reaction_ms, 3);
    chk("basic_state", dbg_state, 3);
    // button held through a second 7 ms window: miss only
    repeat (3) cyc1(1, 0, 0, 1);
    cyc1(1, 1, 0, 1);
    repeat (7) cyc1(1, 1, 1, 1);
    cyc1(1, 0, 0, 1);
    cyc1(1, 0, 0, 0);
    @(negedge clk);
    chk("held_hits", hits, 1);
    chk("held_misses", misses, 1);
    // press lands on the same cycle as the fall
    cyc1(1, 1, 0, 0);
    cyc1(1, 1, 1, 0);
    cyc1(1, 1, 0, 1);
    cyc1(1, 1, 0, 1);
    cyc1(1, 0, 0, 1);
    cyc1(1, 0, 0, 0);
    cyc1(1, 0, 0, 0);
    @(negedge clk);
    chk("simul_hits", hits, 1);
    chk("simul_misses", misses, 2);
    // second hit, then a press while the mole is down
    cyc1(1, 1, 0, 0);
    repeat (3) cyc1(1, 1, 0, 1);
    repeat (2) cyc1(1, 0, 0, 0);
    repeat (3) cyc1(1, 0, 0, 1);
    repeat (2) cyc1(1, 0, 0, 0);
    @(negedge clk);
`ifdef SCORER_PENALTY_EN
    chk("penalty_hits", hits, 1);
    chk("penalty_fw", false_whacks, 1);
`else
    chk("penalty_hits", hits, 2);
    chk("penalty_fw", false_whacks, 0);
`endif
    // restart keeps best reaction
    repeat (2) cyc1(0, 0, 0, 0);
    cyc1(1, 0, 0, 0);
    repeat (2) cyc1(1, 0, 0, 0);
    @(negedge clk);
    chk("restart_hits", hits, 0);
    chk("restart_misses", misses, 0);
    chk("restart_best", best_reaction_ms, 0);
    chk("restart_state", dbg_state, 1);
    for (int n = 0; n < 5000; n++) begin
      if (g_left == 0) begin g_r = !g_r; g_left = g_r ? $urandom_range(150, 500) : $urandom_range(1, 6); end
      else g_left--;
      if (m_left == 0) begin m_r = !m_r; m_left = m_r ? $urandom_range(3, 40) : $urandom_range(2, 30); end
      else m_left--;
      if (b_left == 0) begin b_r = !b_r; b_left = b_r ? $urandom_range(0, 6) : $urandom_range(1, 25); end
      else b_left--;
      cyc1(g_r, m_r, $urandom_range(0, 3) == 0, b_r);
      if (n % 1200 == 600) do_reset();
    end
    repeat (3) cyc1(0, 0, 0, 0);
    @(negedge clk);
    chk("pending_events", ev_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
